data_mem_arbiter: RTL

Shares the single-port data memory between three requesters: control unit load/store (index 0), stack pointer unit PUSH/POP (index 1) and crypto core key/data transfer (index 2).
Sequences each access, handles the 1-cycle synchronous read latency and returns data with a per-requester ack.
Round-robin arbitration; optional lock lets a requester (typically crypto) run back-to-back accesses, bounded by a hold limit.
Sits between the requesters and the data memory instance.

---
 rtl/data_mem_arb_pkg.sv | 17 +
 rtl/rr_pick3.sv | 33 +++
 rtl/data_mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM states and requester indices.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_CU     = 2'd0;
  localparam logic [1:0] REQ_SP     = 2'd1;
  localparam logic [1:0] REQ_CRYPTO = 2'd2;

endpackage

// File: rtl/rr_pick3.sv
// Rotating-priority picker for three requesters; search starts at last+1 mod 3.
module rr_pick3
  import data_mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = REQ_CU;
    case (last)
      2'd0: begin
        if (req[REQ_SP])          winner = REQ_SP;
        else if (req[REQ_CRYPTO]) winner = REQ_CRYPTO;
        else                      winner = REQ_CU;
      end
      2'd1: begin
        if (req[REQ_CRYPTO])      winner = REQ_CRYPTO;
        else if (req[REQ_CU])     winner = REQ_CU;
        else                      winner = REQ_SP;
      end
      default: begin
        if (req[REQ_CU])          winner = REQ_CU;
        else if (req[REQ_SP])     winner = REQ_SP;
        else                      winner = REQ_CRYPTO;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one synchronous single-port data memory between CU, SP unit and crypto core,
// with round-robin arbitration and a bounded ownership lock.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ-1:0]          lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int HCW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(LOCK_MAX);

  state_t          state;
  logic [1:0]      last;
  logic [1:0]      owner;
  logic [1:0]      lock_owner;
  logic            lock_valid;
  logic [HCW-1:0]  hold_cnt;

  logic [1:0]      rr_w;
  logic            rr_valid;
  logic            lock_hit;
  logic [1:0]      win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic            sel_we;

  rr_pick3 u_pick (
    .req    (req),
    .last   (last),
    .winner (rr_w),
    .valid  (rr_valid)
  );

  // Lock only wins while its owner is actually requesting and the hold budget remains.
  always_comb begin
    lock_hit = (LOCK_MAX != 0) && lock_valid && req[lock_owner] && (hold_cnt < HOLD_LIMIT);
    win      = lock_hit ? lock_owner : rr_w;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    case (win)
      2'd1: begin
        sel_addr  = addr_i[ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[DATA_W +: DATA_W];
        sel_we    = we_i[1];
      end
      2'd2: begin
        sel_addr  = addr_i[2*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[2*DATA_W +: DATA_W];
        sel_we    = we_i[2];
      end
      default: begin
        sel_addr  = addr_i[0 +: ADDR_W];
        sel_wdata = wdata_i[0 +: DATA_W];
        sel_we    = we_i[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      ack        <= '0;
      rdata_o    <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last       <= 2'd2;
      owner      <= 2'd0;
      lock_owner <= 2'd0;
      lock_valid <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_valid) begin
            owner     <= win;
            last      <= win;
            gnt       <= 3'b001 << win;
            hold_cnt  <= lock_hit ? hold_cnt + 1'b1 : '0;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            ack[owner] <= 1'b1;
            state      <= RESP;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata_o    <= mem_rdata;
          ack[owner] <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
          if ((LOCK_MAX != 0) && lock_i[owner]) begin
            lock_valid <= 1'b1;
            lock_owner <= owner;
          end else begin
            lock_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
